// File: rtl/chase_pkg.sv
// Shared types and constants for the chasing-LED pattern stage.
package chase_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } chase_state_t;

    localparam int unsigned LED_N    = 16;
    localparam int unsigned POS_W    = 4;
    localparam int unsigned PERIOD_W = 7;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into one-cycle base ticks every BASE_DIV enabled cycles.
module tick_prescaler #(
    parameter int unsigned BASE_DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(BASE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BASE_DIV - 1);

    logic [CNT_W-1:0] base_cnt_q;
    logic [CNT_W-1:0] base_cnt_d;
    logic             at_max;

    assign at_max = (base_cnt_q == CNT_MAX);
    // Gated by en so a paused cycle can never produce a tick.
    assign tick   = en && at_max;

    always_comb begin
        base_cnt_d = base_cnt_q;
        if (en) begin
            base_cnt_d = at_max ? '0 : base_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_cnt_q <= '0;
        end else begin
            base_cnt_q <= base_cnt_d;
        end
    end

endmodule

// File: rtl/chase_core.sv
// Moves a single lit LED across the bar in wrap or bounce mode at a switch-selected rate.
module chase_core
    import chase_pkg::*;
#(
    parameter int unsigned BASE_DIV = 100_000,
    parameter int unsigned LED_N    = chase_pkg::LED_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic [7:0]       sw,
    output logic [LED_N-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [7:0]       laps,
    output logic             step_pulse
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_N - 1);

    logic                base_tick;
    logic                step_due;
    logic                bounce;
    logic [PERIOD_W-1:0] period_m1;

    logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
    chase_state_t        state_q,    state_d;
    logic [POS_W-1:0]    pos_q,      pos_d;
    logic [LED_N-1:0]    led_q,      led_d;
    logic [7:0]          laps_q,     laps_d;
    logic                pulse_q,    pulse_d;

    tick_prescaler #(
        .BASE_DIV(BASE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (!stop),
        .tick (base_tick)
    );

    assign period_m1 = sw[PERIOD_W-1:0];
    assign bounce    = sw[7];
    // >= lets a period shortened mid-count fire on the very next tick.
    assign step_due  = base_tick && (step_cnt_q >= period_m1);

    always_comb begin
        step_cnt_d = step_cnt_q;
        state_d    = state_q;
        pos_d      = pos_q;
        laps_d     = laps_q;
        pulse_d    = 1'b0;

        if (base_tick) begin
            step_cnt_d = step_due ? '0 : step_cnt_q + PERIOD_W'(1);
        end

        if (step_due) begin
            pulse_d = 1'b1;
            if (!bounce) begin
                state_d = UP;
                pos_d   = pos_q + POS_W'(1);
                if (pos_q == POS_MAX) begin
                    laps_d = laps_q + 8'd1;
                end
            end else begin
                case (state_q)
                    UP: begin
                        if (pos_q == POS_MAX) begin
                            pos_d   = POS_MAX - POS_W'(1);
                            state_d = DOWN;
                            laps_d  = laps_q + 8'd1;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end
                    DOWN: begin
                        if (pos_q == '0) begin
                            pos_d   = POS_W'(1);
                            state_d = UP;
                            laps_d  = laps_q + 8'd1;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                    default: state_d = UP;
                endcase
            end
        end

        led_d        = '0;
        led_d[pos_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_q <= '0;
            state_q    <= UP;
            pos_q      <= '0;
            led_q      <= {{(LED_N-1){1'b0}}, 1'b1};
            laps_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            state_q    <= state_d;
            pos_q      <= pos_d;
            led_q      <= led_d;
            laps_q     <= laps_d;
            pulse_q    <= pulse_d;
        end
    end

    assign led        = led_q;
    assign pos        = pos_q;
    assign dir        = (state_q == DOWN);
    assign laps       = laps_q;
    assign step_pulse = pulse_q;

endmodule

// File: doc/chase_core.md
# chase_core

Pattern-generation stage of the chasing-LED design. It sits directly upstream of the LED and seven-segment outputs of `top`. It divides the system clock into step events and moves a single lit LED across a 16-LED bar, either wrapping or bouncing, at a rate set by `sw[6:0]`. It also exports the current position, direction and a lap count for the display driver downstream.

## Interface
- `BASE_DIV`, default 100_000: clock cycles per base tick (1 ms at 100 MHz); at least 2.
- `LED_N`, default 16: LED bar width; fixed at 16 in this revision.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stop` in 1: level-sensitive pause; high freezes all state.
- `sw` in 8: `sw[6:0]` selects the step period, `sw[7]` selects the mode (0 = wrap, 1 = bounce).
- `led` out 16: one-hot LED image; bit `pos` is set.
- `pos` out 4: index of the lit LED.
- `dir` out 1: direction of the next step (0 = up, 1 = down).
- `laps` out 8: count of end events (wraps or bounces), modulo 256.
- `step_pulse` out 1: single-cycle strobe, high in the cycle that `pos` takes a new value.

## Operation
- Prescaler:
  - `base_cnt` counts 0 to BASE_DIV-1, then wraps to 0.
  - `base_tick` is asserted when `base_cnt` equals BASE_DIV-1.
- Step counter:
  - `step_cnt` (7 bits) increments on each `base_tick`.
  - Period P = `sw[6:0]` + 1 base ticks, giving a range of 1 to 128.
  - A step is due when `base_tick` is high and `step_cnt` >= P-1; `step_cnt` then clears to 0.
  - The >= comparison means a period shortened mid-count steps on the next `base_tick` and does not run through 128 ticks.
- `sw` is sampled every cycle, with no latching; a period or mode change takes effect at the next due step.
- FSM `chase_state_t` has two states, UP and DOWN, and `dir` is 1 exactly in DOWN.
- Wrap mode (`sw[7]` = 0):
  - A step in UP does `pos` + 1. From 15 it goes to 0 and `laps` increments.
  - A step taken in DOWN moves to UP and performs an up-move in the same step.
- Bounce mode (`sw[7]` = 1):
  - UP at `pos` < 15: `pos` + 1.
  - UP at 15: `pos` becomes 14, state becomes DOWN, `laps` increments.
  - DOWN at `pos` > 0: `pos` - 1.
  - DOWN at 0: `pos` becomes 1, state becomes UP, `laps` increments.
- `stop` high:
  - `base_cnt`, `step_cnt`, state, `pos` and `laps` all hold; nothing is cleared.
  - When `stop` falls, counting resumes from the held counts.
- `led` = 1 << `pos`, registered together with `pos` so that exactly one bit is always high.
- `laps` wraps from 255 to 0 silently.

## Timing
- Reset values: `pos` = 0, `led` = 16'h0001, `dir` = 0 (state UP), `laps` = 0, `step_pulse` = 0, `base_cnt` = 0, `step_cnt` = 0.
- Reset has priority over `stop` and over any step.
- A step due in cycle N (with `stop` low in N) updates `pos`, `led`, `dir` and `laps` at the edge ending N. `step_pulse` is high throughout cycle N+1.
- Step latency after `stop` falls or reset releases: the first step occurs P·BASE_DIV cycles after the first unfrozen cycle.
- If `stop` is high in the same cycle that a step is due, `stop` wins: no step, no pulse, no counter advance.
- Reset asserted mid-period clears all state at the next edge, including any pending pulse.
- `step_pulse` is never high for 2 consecutive cycles, because BASE_DIV >= 2.

## Structure
- `chase_pkg` holds:
  - `chase_state_t` (UP, DOWN);
  - `LED_N`;
  - `POS_W` = 4;
  - `PERIOD_W` = 7.
- Sub-module `tick_prescaler` (parameter BASE_DIV; ports `clk`, `reset`, `en`, `tick`) holds `base_cnt`. Its `en` input is driven by `!stop`.
- `chase_core` contains the step counter, the FSM and the output registers.

## Test plan
All scenarios use BASE_DIV = 2.
- Reset released, `stop` = 0, `sw` = 8'h00 (wrap, P = 1):
  - Step every 2 cycles; `led` goes 0001, 0002, 0004 and so on.
  - After the 16th step, `pos` = 0 and `laps` = 1.
- `sw` = 8'h80 (bounce, P = 1), run 40 steps:
  - `pos` goes 0…15, 14…0, 1…; `dir` rises on the step to 14.
  - `laps` = 1 at 14 and 2 at 1; at step 40, `pos` = 10.
- `sw` = 8'h7F (wrap, P = 128): first step 256 cycles after reset release, `pos` = 1.
- `sw` = 8'h7F:
  - After `step_cnt` reaches 100, change `sw` to 8'h03 → step on the next `base_tick`, then every 8 cycles.
- `stop` high for 50 cycles mid-period → `pos`, `laps` and counters frozen, no `step_pulse`. After release, the next step arrives after exactly the remaining cycles.
- `reset` pulsed for 1 cycle at `pos` = 9 in DOWN with `laps` = 3 → next cycle: `pos` = 0, `led` = 0001, `dir` = 0, `laps` = 0.
